// File: rtl/bisr_tile_sequencer.sv
// bisr_tile_sequencer: job-level sequencer for the BISR systolic engine.
// Walks an M x N x K tiled matmul one engine pass per tile (m outer, n middle,
// k inner), interleaves stop-the-world self-test runs, keeps a sticky PE fault
// map and aborts the job through a watchdog if the engine stops responding.
module bisr_tile_sequencer #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int ADDR_W     = 32,
    parameter int TILE_IDX_W = 8,
    parameter int TILE_WORDS = ROWS * COLS,
    parameter int STW_PERIOD = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             job_start,
    input  logic [TILE_IDX_W-1:0]            job_m,
    input  logic [TILE_IDX_W-1:0]            job_n,
    input  logic [TILE_IDX_W-1:0]            job_k,
    input  logic [ADDR_W-1:0]                a_base,
    input  logic [ADDR_W-1:0]                b_base,
    input  logic [ADDR_W-1:0]                c_base,
    input  logic                             abort,
    input  logic                             fault_clr,
    output logic                             job_busy,
    output logic                             job_done,
    output logic                             job_err,
    output logic                             eng_stw_req,
    input  logic                             eng_stw_complete,
    input  logic [ROWS*COLS-1:0]             eng_stw_result,
    output logic                             eng_start_fsm,
    input  logic                             eng_fsm_rdy,
    output logic                             eng_start_matmul,
    input  logic                             eng_fsm_done,
    output logic [ADDR_W-1:0]                tile_a_addr,
    output logic [ADDR_W-1:0]                tile_b_addr,
    output logic [ADDR_W-1:0]                tile_c_addr,
    output logic                             tile_accum,
    output logic                             tile_last_k,
    output logic [ROWS*COLS-1:0]             fault_map,
    output logic                             new_fault,
    output logic [$clog2(ROWS*COLS+1)-1:0]   fault_count
);

    localparam int PES    = ROWS * COLS;
    localparam int FC_W   = $clog2(PES + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int TW_W   = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;
    // Linear tile index times stride, with one guard bit for the "+ inner" add.
    localparam int PROD_W = 2 * TILE_IDX_W + TW_W + 1;
    localparam int EXT_W  = (PROD_W > ADDR_W) ? PROD_W : ADDR_W;
    // Wide enough to count every tile of the largest job without wrapping.
    localparam int TSS_W  = 3 * TILE_IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STW,
        S_STW_WAIT,
        S_LOAD,
        S_WAIT_RDY,
        S_RUN,
        S_WAIT_DONE,
        S_ADV
    } state_t;

    state_t                 state;
    logic [TILE_IDX_W-1:0]  m_dim, n_dim, k_dim;
    logic [TILE_IDX_W-1:0]  m_idx, n_idx, k_idx;
    logic [ADDR_W-1:0]      a_reg, b_reg, c_reg;
    logic [TSS_W-1:0]       tiles_since_stw;
    logic [WD_W-1:0]        wd;

    logic [TILE_IDX_W-1:0]  m_nxt, n_nxt, k_nxt;
    logic                   last_tile;
    logic                   stw_due;
    logic [TSS_W-1:0]       tss_inc;
    logic                   in_wait;
    logic                   timeout;
    logic                   stw_accept;
    logic [PES-1:0]         fault_nxt;
    logic                   new_fault_nxt;

    // base + (outer * dim + inner) * TILE_WORDS, truncated to ADDR_W
    function automatic logic [ADDR_W-1:0] tile_addr(
        input logic [ADDR_W-1:0]     base,
        input logic [TILE_IDX_W-1:0] outer,
        input logic [TILE_IDX_W-1:0] dim,
        input logic [TILE_IDX_W-1:0] inner
    );
        logic [EXT_W-1:0] lin;
        lin = EXT_W'(outer) * EXT_W'(dim) + EXT_W'(inner);
        lin = lin * EXT_W'(TILE_WORDS);
        return base + lin[ADDR_W-1:0];
    endfunction

    function automatic logic [FC_W-1:0] popcount(input logic [PES-1:0] v);
        logic [FC_W-1:0] c;
        c = '0;
        for (int i = 0; i < PES; i++) c = c + FC_W'(v[i]);
        return c;
    endfunction

    // Next tile indices in m/n/k loop order, plus the STW-due decision for ADV
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        logic lk, ln, lm;
        lk        = (k_idx == k_dim - TILE_IDX_W'(1));
        ln        = (n_idx == n_dim - TILE_IDX_W'(1));
        lm        = (m_idx == m_dim - TILE_IDX_W'(1));
        k_nxt     = lk ? '0 : k_idx + TILE_IDX_W'(1);
        n_nxt     = n_idx;
        m_nxt     = m_idx;
        if (lk) n_nxt = ln ? '0 : n_idx + TILE_IDX_W'(1);
        if (lk && ln) m_nxt = m_idx + TILE_IDX_W'(1);
        last_tile = lk && ln && lm;
        tss_inc   = tiles_since_stw + TSS_W'(1);
        stw_due   = (STW_PERIOD != 0) && (tss_inc == TSS_W'(STW_PERIOD));
    end

    assign in_wait    = (state == S_STW_WAIT) || (state == S_WAIT_RDY) || (state == S_WAIT_DONE);
    assign timeout    = in_wait && (wd == WD_W'(TIMEOUT - 1));
    assign stw_accept = (state == S_STW_WAIT) && eng_stw_complete && !abort && !timeout;

    // Fault map update: a clear coinciding with a result keeps only the new result
    always_comb begin
        fault_nxt     = fault_map;
        new_fault_nxt = 1'b0;
        if (stw_accept && fault_clr) begin
            fault_nxt     = eng_stw_result;
            new_fault_nxt = |eng_stw_result;
        end else if (stw_accept) begin
            fault_nxt     = fault_map | eng_stw_result;
            new_fault_nxt = |(eng_stw_result & ~fault_map);
        end else if (fault_clr) begin
            fault_nxt     = '0;
        end
    end

    // Sticky fault map and its popcount; persists across jobs
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            fault_map   <= '0;
            fault_count <= '0;
            new_fault   <= 1'b0;
        end else begin
            fault_map   <= fault_nxt;
            fault_count <= popcount(fault_nxt);
            new_fault   <= new_fault_nxt;
        end
    end

    // Job FSM with registered pulses, tile addresses and watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            m_dim            <= '0;
            n_dim            <= '0;
            k_dim            <= '0;
            m_idx            <= '0;
            n_idx            <= '0;
            k_idx            <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            c_reg            <= '0;
            tiles_since_stw  <= '0;
            wd               <= '0;
            job_busy         <= 1'b0;
            job_done         <= 1'b0;
            job_err          <= 1'b0;
            eng_stw_req      <= 1'b0;
            eng_start_fsm    <= 1'b0;
            eng_start_matmul <= 1'b0;
            tile_a_addr      <= '0;
            tile_b_addr      <= '0;
            tile_c_addr      <= '0;
            tile_accum       <= 1'b0;
            tile_last_k      <= 1'b0;
        end else begin
            job_done         <= 1'b0;
            job_err          <= 1'b0;
            eng_stw_req      <= 1'b0;
            eng_start_fsm    <= 1'b0;
            eng_start_matmul <= 1'b0;
            wd               <= '0;
            if ((state != S_IDLE) && abort) begin
                state    <= S_IDLE;
                job_busy <= 1'b0;
                job_err  <= 1'b1;
            end else if (timeout) begin
                state    <= S_IDLE;
                job_busy <= 1'b0;
                job_err  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (job_start) begin
                            if ((job_m == '0) || (job_n == '0) || (job_k == '0)) begin
                                job_err <= 1'b1;
                            end else begin
                                m_dim           <= job_m;
                                n_dim           <= job_n;
                                k_dim           <= job_k;
                                a_reg           <= a_base;
                                b_reg           <= b_base;
                                c_reg           <= c_base;
                                m_idx           <= '0;
                                n_idx           <= '0;
                                k_idx           <= '0;
                                tiles_since_stw <= '0;
                                tile_a_addr     <= a_base;
                                tile_b_addr     <= b_base;
                                tile_c_addr     <= c_base;
                                tile_accum      <= 1'b0;
                                tile_last_k     <= (job_k == TILE_IDX_W'(1));
                                job_busy        <= 1'b1;
                                eng_stw_req     <= 1'b1;
                                state           <= S_STW;
                            end
                        end
                    end
                    S_STW: state <= S_STW_WAIT;
                    S_STW_WAIT: begin
                        wd <= wd + WD_W'(1);
                        if (eng_stw_complete) begin
                            tiles_since_stw <= '0;
                            eng_start_fsm   <= 1'b1;
                            state           <= S_LOAD;
                        end
                    end
                    S_LOAD: state <= S_WAIT_RDY;
                    S_WAIT_RDY: begin
                        wd <= wd + WD_W'(1);
                        if (eng_fsm_rdy) begin
                            eng_start_matmul <= 1'b1;
                            state            <= S_RUN;
                        end
                    end
                    S_RUN: state <= S_WAIT_DONE;
                    S_WAIT_DONE: begin
                        wd <= wd + WD_W'(1);
                        if (eng_fsm_done) state <= S_ADV;
                    end
                    S_ADV: begin
                        tiles_since_stw <= tss_inc;
                        if (last_tile) begin
                            job_done <= 1'b1;
                            job_busy <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            m_idx       <= m_nxt;
                            n_idx       <= n_nxt;
                            k_idx       <= k_nxt;
                            tile_a_addr <= tile_addr(a_reg, m_nxt, k_dim, k_nxt);
                            tile_b_addr <= tile_addr(b_reg, k_nxt, n_dim, n_nxt);
                            tile_c_addr <= tile_addr(c_reg, m_nxt, n_dim, n_nxt);
                            tile_accum  <= (k_nxt != '0);
                            tile_last_k <= (k_nxt == k_dim - TILE_IDX_W'(1));
                            if (stw_due) begin
                                eng_stw_req <= 1'b1;
                                state       <= S_STW;
                            end else begin
                                eng_start_fsm <= 1'b1;
                                state         <= S_LOAD;
                            end
                        end
                    end
                    default: begin
                        job_busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bisr_tile_sequencer.sv
// Self-checking bench for bisr_tile_sequencer: emulates the engine handshakes,
// predicts tile order, addresses, STW placement and the fault map from the
// job description, and compares at every handshake point.
module tb_bisr_tile_sequencer;

    localparam int STW_P = 2;
    localparam int TO    = 16;
    localparam int TW    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_start = 1'b0;
    logic [7:0]  job_m = '0, job_n = '0, job_k = '0;
    logic [31:0] a_base = '0, b_base = '0, c_base = '0;
    logic        abort = 1'b0;
    logic        fault_clr = 1'b0;
    logic        job_busy, job_done, job_err;
    logic        eng_stw_req;
    logic        eng_stw_complete = 1'b0;
    logic [15:0] eng_stw_result = '0;
    logic        eng_start_fsm;
    logic        eng_fsm_rdy = 1'b0;
    logic        eng_start_matmul;
    logic        eng_fsm_done = 1'b0;
    logic [31:0] tile_a_addr, tile_b_addr, tile_c_addr;
    logic        tile_accum, tile_last_k;
    logic [15:0] fault_map;
    logic        new_fault;
    logic [4:0]  fault_count;

    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    logic [15:0] model_fm = '0;

    always #5 clk = ~clk;

    bisr_tile_sequencer #(
        .ROWS(4), .COLS(4), .ADDR_W(32), .TILE_IDX_W(8), .TILE_WORDS(TW),
        .STW_PERIOD(STW_P), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .job_start(job_start),
        .job_m(job_m), .job_n(job_n), .job_k(job_k),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .abort(abort), .fault_clr(fault_clr),
        .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
        .eng_stw_req(eng_stw_req), .eng_stw_complete(eng_stw_complete),
        .eng_stw_result(eng_stw_result), .eng_start_fsm(eng_start_fsm),
        .eng_fsm_rdy(eng_fsm_rdy), .eng_start_matmul(eng_start_matmul),
        .eng_fsm_done(eng_fsm_done),
        .tile_a_addr(tile_a_addr), .tile_b_addr(tile_b_addr), .tile_c_addr(tile_c_addr),
        .tile_accum(tile_accum), .tile_last_k(tile_last_k),
        .fault_map(fault_map), .new_fault(new_fault), .fault_count(fault_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int m, input int n, input int k,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        job_m     = 8'(m);
        job_n     = 8'(n);
        job_k     = 8'(k);
        a_base    = a;
        b_base    = b;
        c_base    = c;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
    endtask

    task automatic pulse_fault_clr();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        model_fm  = '0;
        check("clr_fault_map", fault_map, 0);
        check("clr_fault_count", fault_count, 0);
    endtask

    // Run one job end to end; abort_tile >= 0 aborts that tile in WAIT_DONE.
    task automatic run_job(input int m, input int n, input int k,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [15:0] res, input bit clr_at_stw, input int abort_tile);
        int          t;
        int          d;
        logic [31:0] ea, eb, ec;
        logic        exp_new;
        logic        seen_done;
        start_job(m, n, k, a, b, c);
        check("accept_busy", job_busy, 1);
        t = 0;
        for (int mi = 0; mi < m; mi++) begin
            for (int ni = 0; ni < n; ni++) begin
                for (int ki = 0; ki < k; ki++) begin
                    ea = a + 32'((mi * k + ki) * TW);
                    eb = b + 32'((ki * n + ni) * TW);
                    ec = c + 32'((mi * n + ni) * TW);
                    if (t % STW_P == 0) begin
                        check("stw_req", eng_stw_req, 1);
                        @(negedge clk);
                        d = $urandom_range(0, 3);
                        repeat (d) begin
                            eng_fsm_rdy  = 1'($urandom_range(0, 1));
                            eng_fsm_done = 1'($urandom_range(0, 1));
                            @(negedge clk);
                        end
                        eng_fsm_rdy      = 1'b0;
                        eng_fsm_done     = 1'b0;
                        eng_stw_complete = 1'b1;
                        eng_stw_result   = res;
                        fault_clr        = clr_at_stw;
                        @(negedge clk);
                        eng_stw_complete = 1'b0;
                        fault_clr        = 1'b0;
                        eng_stw_result   = 16'($urandom);
                        if (clr_at_stw) begin
                            exp_new  = |res;
                            model_fm = res;
                        end else begin
                            exp_new  = |(res & ~model_fm);
                            model_fm = model_fm | res;
                        end
                        check("fault_map", fault_map, model_fm);
                        check("fault_count", fault_count, $countones(model_fm));
                        check("new_fault", new_fault, exp_new);
                    end else begin
                        check("no_stw_req", eng_stw_req, 0);
                    end
                    check("start_fsm", eng_start_fsm, 1);
                    check("tile_a", tile_a_addr, ea);
                    check("tile_b", tile_b_addr, eb);
                    check("tile_c", tile_c_addr, ec);
                    check("tile_accum", tile_accum, ki != 0);
                    check("tile_last_k", tile_last_k, ki == k - 1);
                    @(negedge clk);
                    check("new_fault_pulse", new_fault, 0);
                    d = $urandom_range(0, 4);
                    repeat (d) begin
                        eng_fsm_done     = 1'($urandom_range(0, 1));
                        eng_stw_complete = 1'($urandom_range(0, 1));
                        eng_stw_result   = 16'($urandom);
                        @(negedge clk);
                    end
                    eng_fsm_done     = 1'b0;
                    eng_stw_complete = 1'b0;
                    eng_fsm_rdy      = 1'b1;
                    @(negedge clk);
                    eng_fsm_rdy = 1'b0;
                    check("start_matmul", eng_start_matmul, 1);
                    @(negedge clk);
                    d = $urandom_range(0, 4);
                    repeat (d) begin
                        eng_fsm_rdy = 1'($urandom_range(0, 1));
                        job_start   = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                    eng_fsm_rdy = 1'b0;
                    job_start   = 1'b0;
                    if (t == abort_tile) begin
                        abort = 1'b1;
                        @(negedge clk);
                        abort = 1'b0;
                        check("abort_busy", job_busy, 0);
                        check("abort_err", job_err, 1);
                        seen_done = 1'b0;
                        repeat (4) begin
                            eng_fsm_done = 1'b1;
                            @(negedge clk);
                            seen_done = seen_done | job_done;
                        end
                        eng_fsm_done = 1'b0;
                        check("abort_no_done", seen_done, 0);
                        check("abort_idle", job_busy, 0);
                        return;
                    end
                    eng_fsm_done = 1'b1;
                    @(negedge clk);
                    eng_fsm_done = 1'b0;
                    check("adv_busy", job_busy, 1);
                    check("adv_no_done", job_done, 0);
                    check("adv_addr_stable", tile_a_addr, ea);
                    check("adv_fault_map", fault_map, model_fm);
                    @(negedge clk);
                    t++;
                end
            end
        end
        check("job_done", job_done, 1);
        check("done_busy", job_busy, 0);
        check("done_no_err", job_err, 0);
        @(negedge clk);
        check("done_pulse", job_done, 0);
    endtask

    initial begin
        int err_at;
        repeat (3) @(negedge clk);
        check("rst_busy", job_busy, 0);
        check("rst_done", job_done, 0);
        check("rst_err", job_err, 0);
        check("rst_stw_req", eng_stw_req, 0);
        check("rst_tile_a", tile_a_addr, 0);
        check("rst_tile_c", tile_c_addr, 0);
        check("rst_last_k", tile_last_k, 0);
        check("rst_fault_map", fault_map, 0);
        check("rst_fault_count", fault_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", job_busy, 0);

        run_job(1, 1, 1, 32'h100, 32'h200, 32'h300, 16'h0000, 1'b0, -1);
        run_job(2, 1, 2, 32'h0, 32'h1000, 32'h2000, 16'h0000, 1'b0, -1);
        run_job(5, 1, 1, 32'h4000, 32'h5000, 32'h6000, 16'h0000, 1'b0, -1);

        run_job(1, 1, 1, 32'h0, 32'h0, 32'h0, 16'h0010, 1'b0, -1);
        run_job(1, 1, 1, 32'h0, 32'h0, 32'h0, 16'h0011, 1'b0, -1);
        run_job(1, 1, 1, 32'h0, 32'h0, 32'h0, 16'h0011, 1'b0, -1);
        pulse_fault_clr();
        run_job(1, 1, 1, 32'h0, 32'h0, 32'h0, 16'h0000, 1'b0, -1);
        run_job(1, 2, 1, 32'h10, 32'h20, 32'h30, 16'h0300, 1'b0, -1);
        run_job(1, 1, 1, 32'h10, 32'h20, 32'h30, 16'h0100, 1'b1, -1);

        job_m = 8'd3; job_n = 8'd2; job_k = 8'd0;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        check("reject_err", job_err, 1);
        check("reject_busy", job_busy, 0);
        check("reject_no_stw", eng_stw_req, 0);
        @(negedge clk);
        check("reject_err_pulse", job_err, 0);
        check("reject_still_idle", job_busy, 0);

        run_job(2, 2, 2, 32'h8000, 32'h9000, 32'hA000, 16'h0000, 1'b0, 1);

        start_job(1, 1, 1, 32'h100, 32'h200, 32'h300);
        check("to_stw_req", eng_stw_req, 1);
        @(negedge clk);
        eng_stw_complete = 1'b1;
        eng_stw_result   = 16'h0000;
        @(negedge clk);
        eng_stw_complete = 1'b0;
        check("to_start_fsm", eng_start_fsm, 1);
        @(negedge clk);
        err_at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (job_err) begin
                err_at = i;
                break;
            end
        end
        check("timeout_cycles", err_at, TO);
        check("timeout_idle", job_busy, 0);
        @(negedge clk);
        run_job(1, 2, 2, 32'h300, 32'h400, 32'h500, 16'h0000, 1'b0, -1);

        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                    $urandom, $urandom, $urandom,
                    16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) == 0), -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "bench stalled");
    end

endmodule
